// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : lcd_timing_gen
// Purpose : RGB565 LCD timing generator with frame-latched test patterns.
// Revision: 1.0  initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FP       = 210,
    parameter int   H_SYNC     = 1,
    parameter int   H_BP       = 182,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 45,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 0,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   CHECK_LOG2 = 5,
    parameter int   CW         = 16
) (
    input  logic          PixelClk,
    input  logic          nRST,
    input  logic [1:0]    pattern_sel,
    input  logic [15:0]   solid_rgb,
    output logic          LCD_DE,
    output logic          LCD_HSYNC,
    output logic          LCD_VSYNC,
    output logic [4:0]    LCD_R,
    output logic [5:0]    LCD_G,
    output logic [4:0]    LCD_B,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam int c_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_BAR_W   = H_ACTIVE / 8;

    localparam logic [CW-1:0] c_H_LAST      = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST      = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_SYNC      = CW'(H_SYNC);
    localparam logic [CW-1:0] c_V_SYNC      = CW'(V_SYNC);
    localparam logic [CW-1:0] c_H_VIS_START = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] c_H_VIS_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] c_V_VIS_START = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] c_V_VIS_END   = CW'(V_SYNC + V_BP + V_ACTIVE);

    generate
        if (H_ACTIVE < 8 || V_ACTIVE < 8) begin : g_bad_active
            $fatal(1, "lcd_timing_gen: H_ACTIVE and V_ACTIVE must be >= 8");
        end
        if (longint'(c_H_TOTAL) >= (longint'(1) << CW) ||
            longint'(c_V_TOTAL) >= (longint'(1) << CW)) begin : g_bad_total
            $fatal(1, "lcd_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
        end
    endgenerate

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [1:0]    r_pat;
    logic          r_run;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_frame0;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_h_vis;
    logic          w_v_vis;
    logic          w_de;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic [1:0]    w_pat;
    logic [2:0]    w_bar;
    logic [5:0]    w_gv;
    logic [15:0]   w_rgb;

    assign w_h_wrap = (r_h_cnt == c_H_LAST);
    assign w_v_wrap = (r_v_cnt == c_V_LAST);
    assign w_frame0 = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CW'(1);
        end
    end

    assign w_hs_act = (r_h_cnt < c_H_SYNC);
    assign w_vs_act = (r_v_cnt < c_V_SYNC);
    assign w_h_vis  = (r_h_cnt >= c_H_VIS_START) && (r_h_cnt < c_H_VIS_END);
    assign w_v_vis  = (r_v_cnt >= c_V_VIS_START) && (r_v_cnt < c_V_VIS_END);
    assign w_de     = w_h_vis && w_v_vis;
    assign w_x      = r_h_cnt - c_H_VIS_START;
    assign w_y      = r_v_cnt - c_V_VIS_START;

    // The first cycle of a frame already uses the newly captured selection.
    assign w_pat = w_frame0 ? pattern_sel : r_pat;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_pat <= 2'd0;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_frame0) begin
                r_pat <= pattern_sel;
            end
        end
    end

    // Bar index by threshold compare; the last bar absorbs the remainder.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_x >= CW'(k * c_BAR_W)) begin
                w_bar = 3'(k);
            end
        end
    end

    assign w_gv = w_x[7:2];

    always_comb begin
        w_rgb = 16'h0000;
        case (w_pat)
            2'd0:    w_rgb = {{5{~w_bar[1]}}, {6{~w_bar[2]}}, {5{~w_bar[0]}}};
            2'd1:    w_rgb = {w_gv[5:1], w_gv, w_gv[5:1]};
            2'd2:    w_rgb = (w_x[CHECK_LOG2] ^ w_y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
            default: w_rgb = solid_rgb;
        endcase
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            LCD_DE      <= 1'b0;
            LCD_HSYNC   <= ~HS_POL;
            LCD_VSYNC   <= ~VS_POL;
            LCD_R       <= 5'd0;
            LCD_G       <= 6'd0;
            LCD_B       <= 5'd0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            LCD_DE      <= w_de;
            LCD_HSYNC   <= w_hs_act ? HS_POL : ~HS_POL;
            LCD_VSYNC   <= w_vs_act ? VS_POL : ~VS_POL;
            {LCD_R, LCD_G, LCD_B} <= w_de ? w_rgb : 16'h0000;
            pixel_x     <= w_de ? w_x : '0;
            pixel_y     <= w_de ? w_y : '0;
            frame_start <= w_frame0 && r_run;
            if (w_frame0 && r_run) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_timing_gen
// Purpose : Self-checking bench for lcd_timing_gen (two geometries).
// Revision: 1.0  initial release
// ============================================================================
module tb_lcd_timing_gen;

    typedef struct {int hs, hb, ha, hf, vs, vb, va, vf, hpol, vpol, ck;} geo_t;
    typedef struct {int de, hs, vs, rgb, x, y, fs, fc;} out_t;
    typedef struct {int dut; int pat; int x; int y; int rgb;} vec_t;

    logic        clk = 1'b0;
    logic        nRST;
    logic [1:0]  selA, selC;
    logic [15:0] solidA, solidC;

    logic        deA, hsA, vsA, fsA;
    logic [4:0]  rA, bA;
    logic [5:0]  gA;
    logic [15:0] xA, yA, fcA;
    logic        deC, hsC, vsC, fsC;
    logic [4:0]  rC, bC;
    logic [5:0]  gC;
    logic [15:0] xC, yC, fcC;

    int checks   = 0;
    int failures = 0;

    geo_t geoA = '{2, 2, 16, 2, 2, 2, 8, 2, 1, 1, 2};
    geo_t geoC = '{1, 2, 800, 3, 1, 1, 8, 1, 0, 0, 5};

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_LOG2(2), .CW(16)
    ) u_dut_a (
        .PixelClk(clk), .nRST(nRST), .pattern_sel(selA), .solid_rgb(solidA),
        .LCD_DE(deA), .LCD_HSYNC(hsA), .LCD_VSYNC(vsA),
        .LCD_R(rA), .LCD_G(gA), .LCD_B(bA),
        .pixel_x(xA), .pixel_y(yA), .frame_start(fsA), .frame_count(fcA)
    );

    lcd_timing_gen #(
        .H_ACTIVE(800), .H_FP(3), .H_SYNC(1), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(5), .CW(16)
    ) u_dut_c (
        .PixelClk(clk), .nRST(nRST), .pattern_sel(selC), .solid_rgb(solidC),
        .LCD_DE(deC), .LCD_HSYNC(hsC), .LCD_VSYNC(vsC),
        .LCD_R(rC), .LCD_G(gC), .LCD_B(bC),
        .pixel_x(xC), .pixel_y(yC), .frame_start(fsC), .frame_count(fcC)
    );

    function automatic int htot(geo_t g);
        return g.hs + g.hb + g.ha + g.hf;
    endfunction

    function automatic int ftot(geo_t g);
        return htot(g) * (g.vs + g.vb + g.va + g.vf);
    endfunction

    function automatic int bar_rgb(int b);
        case (b)
            0: return 'hFFFF;  // white
            1: return 'hFFE0;  // yellow
            2: return 'h07FF;  // cyan
            3: return 'h07E0;  // green
            4: return 'hF81F;  // magenta
            5: return 'hF800;  // red
            6: return 'h001F;  // blue
            default: return 0; // black
        endcase
    endfunction

    function automatic out_t reset_out(geo_t g);
        out_t o;
        o = '{0, 1 - g.hpol, 1 - g.vpol, 0, 0, 0, 0, 0};
        return o;
    endfunction

    // Panel output for the position s cycles into a frame.
    function automatic out_t model(geo_t g, int s, int pat, int solid);
        out_t o;
        int h, v, b, gv;
        h = s % htot(g);
        v = s / htot(g);
        o = '{0, 0, 0, 0, 0, 0, 0, 0};
        o.hs = (h < g.hs) ? g.hpol : 1 - g.hpol;
        o.vs = (v < g.vs) ? g.vpol : 1 - g.vpol;
        o.de = (h >= g.hs + g.hb && h < g.hs + g.hb + g.ha &&
                v >= g.vs + g.vb && v < g.vs + g.vb + g.va) ? 1 : 0;
        if (o.de == 1) begin
            o.x = h - g.hs - g.hb;
            o.y = v - g.vs - g.vb;
            case (pat)
                0: begin
                    b = o.x / (g.ha / 8);
                    if (b > 7) b = 7;
                    o.rgb = bar_rgb(b);
                end
                1: begin
                    gv = (o.x / 4) % 64;
                    o.rgb = ((gv / 2) * 2048) + (gv * 32) + (gv / 2);
                end
                2: o.rgb = (((o.x >> g.ck) ^ (o.y >> g.ck)) & 1) ? 'hFFFF : 0;
                default: o.rgb = solid;
            endcase
        end
        return o;
    endfunction

    int   nA, nC, sA, sC, patA_m, patC_m, fprevA, fprevC;
    out_t expA, expC;

    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            nA = 0; patA_m = 0; expA = reset_out(geoA);
        end else begin
            sA = nA % ftot(geoA);
            if (sA == 0) patA_m = int'(selA);
            fprevA = expA.fc;
            expA = model(geoA, sA, patA_m, int'(solidA));
            expA.fs = (sA == 0 && nA > 0) ? 1 : 0;
            expA.fc = (fprevA + expA.fs) % 65536;
            nA++;
        end
    end

    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            nC = 0; patC_m = 0; expC = reset_out(geoC);
        end else begin
            sC = nC % ftot(geoC);
            if (sC == 0) patC_m = int'(selC);
            fprevC = expC.fc;
            expC = model(geoC, sC, patC_m, int'(solidC));
            expC.fs = (sC == 0 && nC > 0) ? 1 : 0;
            expC.fc = (fprevC + expC.fs) % 65536;
            nC++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string d, input out_t e, input int de, input int hs,
                           input int vs, input int rgb, input int x, input int y,
                           input int fs, input int fc);
        chk({d, "_de"}, de, e.de);
        chk({d, "_hsync"}, hs, e.hs);
        chk({d, "_vsync"}, vs, e.vs);
        chk({d, "_rgb"}, rgb, e.rgb);
        chk({d, "_x"}, x, e.x);
        chk({d, "_y"}, y, e.y);
        chk({d, "_fstart"}, fs, e.fs);
        chk({d, "_fcount"}, fc, e.fc);
    endtask

    always @(negedge clk) begin
        cmp_all("A", expA, int'(deA), int'(hsA), int'(vsA), int'({rA, gA, bA}),
                int'(xA), int'(yA), int'(fsA), int'(fcA));
        cmp_all("C", expC, int'(deC), int'(hsC), int'(vsC), int'({rC, gC, bC}),
                int'(xC), int'(yC), int'(fsC), int'(fcC));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fs(input int d);
        bit found;
        found = 0;
        for (int k = 0; k < 20000 && !found; k++) begin
            tick();
            if ((d == 0) ? fsA : fsC) found = 1;
        end
        if (!found) chk("wait_frame_start", 0, 1);
    endtask

    vec_t vt[12];
    int   cur_pat[2];

    initial begin
        int fc0, n_bad, n_de, n_fs, n_hs, n_vs, de_n, fs_n, dec_n;
        bit found;

        nRST = 1'b0; selA = 2'd0; selC = 2'd0; solidA = 16'h0; solidC = 16'h0;
        repeat (3) tick();
        chk("rst_deA", int'(deA), 0);
        chk("rst_hsA", int'(hsA), 0);
        chk("rst_vsA", int'(vsA), 0);
        chk("rst_hsC", int'(hsC), 1);
        chk("rst_vsC", int'(vsC), 1);
        chk("rst_fcA", int'(fcA), 0);
        nRST = 1'b1;

        vt[0]  = '{1, 0,   0, 0, 'hFFFF};
        vt[1]  = '{1, 0, 100, 0, 'hFFE0};
        vt[2]  = '{1, 0, 699, 0, 'h001F};
        vt[3]  = '{1, 0, 700, 0, 'h0000};
        vt[4]  = '{1, 0, 799, 0, 'h0000};
        vt[5]  = '{1, 1,   4, 0, 'h0020};
        vt[6]  = '{1, 1, 255, 0, 'hFFFF};
        vt[7]  = '{1, 1, 256, 0, 'h0000};
        vt[8]  = '{0, 2,   0, 0, 'h0000};
        vt[9]  = '{0, 2,   4, 0, 'hFFFF};
        vt[10] = '{0, 2,   4, 4, 'h0000};
        vt[11] = '{0, 2,   0, 4, 'hFFFF};
        cur_pat[0] = 0;
        cur_pat[1] = 0;

        foreach (vt[i]) begin
            if (cur_pat[vt[i].dut] != vt[i].pat) begin
                if (vt[i].dut == 0) selA = 2'(vt[i].pat);
                else                selC = 2'(vt[i].pat);
                wait_fs(vt[i].dut);
                cur_pat[vt[i].dut] = vt[i].pat;
            end
            found = 0;
            for (int k = 0; k < 20000 && !found; k++) begin
                tick();
                if (vt[i].dut == 0) begin
                    if (deA && int'(xA) == vt[i].x && int'(yA) == vt[i].y) begin
                        found = 1;
                        chk($sformatf("vec%0d_rgbA", i), int'({rA, gA, bA}), vt[i].rgb);
                    end
                end else begin
                    if (deC && int'(xC) == vt[i].x && int'(yC) == vt[i].y) begin
                        found = 1;
                        chk($sformatf("vec%0d_rgbC", i), int'({rC, gC, bC}), vt[i].rgb);
                    end
                end
            end
            if (!found) chk($sformatf("vec%0d_found", i), 0, 1);
        end

        // Sync/DE occupancy over one full frame of each geometry.
        wait_fs(0);
        n_hs = int'(hsA); n_vs = int'(vsA); n_de = int'(deA);
        repeat (307) begin
            tick();
            n_hs += int'(hsA); n_vs += int'(vsA); n_de += int'(deA);
        end
        chk("A_hsync_high_cycles", n_hs, 28);
        chk("A_vsync_high_cycles", n_vs, 44);
        chk("A_de_cycles", n_de, 128);
        tick();
        chk("A_frame_period", int'(fsA), 1);

        wait_fs(1);
        n_hs = int'(!hsC); n_vs = int'(!vsC); n_de = int'(deC);
        repeat (8865) begin
            tick();
            n_hs += int'(!hsC); n_vs += int'(!vsC); n_de += int'(deC);
        end
        chk("C_hsync_low_cycles", n_hs, 11);
        chk("C_vsync_low_cycles", n_vs, 806);
        chk("C_de_cycles", n_de, 6400);
        tick();
        chk("C_frame_period", int'(fsC), 1);

        // Mid-frame switch bars -> solid: current frame keeps bars.
        selA = 2'd0;
        wait_fs(0);
        wait_fs(0);
        fc0 = int'(fcA);
        repeat (120) tick();
        selA = 2'd3; solidA = 16'hF800;
        n_bad = 0; found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (fsA) found = 1;
            else if (deA && int'({rA, gA, bA}) != bar_rgb((int'(xA) / 2 > 7) ? 7 : int'(xA) / 2))
                n_bad++;
        end
        chk("switch_old_frame_bars", n_bad, 0);
        chk("switch_fs_seen", int'(found), 1);
        chk("switch_fcount_1", int'(fcA), (fc0 + 1) % 65536);
        n_bad = 0; n_de = 0; n_fs = 0;
        repeat (307) begin
            tick();
            if (deA) begin
                n_de++;
                if ({rA, gA, bA} != 16'hF800) n_bad++;
            end
            n_fs += int'(fsA);
        end
        chk("switch_new_frame_solid", n_bad, 0);
        chk("switch_new_frame_de", n_de, 128);
        chk("switch_no_extra_fs", n_fs, 0);
        tick();
        chk("switch_next_fs", int'(fsA), 1);
        chk("switch_fcount_2", int'(fcA), (fc0 + 2) % 65536);

        // Asynchronous reset in the middle of an active line.
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (deA && xA == 16'd5) found = 1;
        end
        chk("reset_found_active", int'(found), 1);
        nRST = 1'b0;
        #1;
        chk("async_rst_de", int'(deA), 0);
        chk("async_rst_rgb", int'({rA, gA, bA}), 0);
        chk("async_rst_x", int'(xA), 0);
        chk("async_rst_hs", int'(hsA), 0);
        chk("async_rst_fc", int'(fcA), 0);
        chk("async_rst_hsC", int'(hsC), 1);
        repeat (3) tick();
        nRST = 1'b1;
        de_n = 0; fs_n = 0; dec_n = 0;
        for (int n = 1; n <= 2000; n++) begin
            tick();
            if (de_n == 0 && deA) de_n = n;
            if (fs_n == 0 && fsA) fs_n = n;
            if (dec_n == 0 && deC) dec_n = n;
        end
        chk("restart_first_de_A", de_n, 4 * 22 + 4 + 1);
        chk("restart_first_fs_A", fs_n, 308 + 1);
        chk("restart_first_de_C", dec_n, 2 * 806 + 3 + 1);

        // Randomised inputs and occasional resets against the model.
        for (int k = 0; k < 4000; k++) begin
            tick();
            if ($urandom_range(0, 99) < 3) selA = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 3) selC = 2'($urandom_range(0, 3));
            solidA = 16'($urandom);
            solidC = 16'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                nRST = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                nRST = 1'b1;
            end
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
